fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller for the universal FIFO. Runs in the read clock domain, tracks the read pointer against a write pointer already delivered into this domain, and issues reads to the block-RAM read port (one-cycle registered read latency). Returned words are presented on a valid/ready stream with first-word-fall-through behaviour. A 2-entry prefetch buffer hides the RAM latency, so a continuously ready consumer sees one word per cycle.

## Interface
- DATA_WIDTH, 32, word width; must match the storage memory.
- MEM_DEPTH, 150, number of memory words; any value ≥ 2, not restricted to a power of two. AW = $clog2(MEM_DEPTH).

- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- rd_rst_n  in  1  asynchronous, active-low reset.
- wr_ptr_i  in  AW+1  write pointer {wrap bit, address}, already stable in the rd_clk domain.
- rd_ptr_o  out  AW+1  read pointer {wrap bit, address} of the next word to fetch; registered.
- mem_rd_en_o  out  1  read enable to the memory read port.
- mem_rd_addr_o  out  AW  read address; equals rd_ptr_o[AW-1:0].
- mem_rd_data_i  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en_o.
- m_valid_o  out  1  output word valid.
- m_ready_i  in  1  consumer accepts the word.
- m_data_o  out  DATA_WIDTH  head of the prefetch buffer.
- empty_o  out  1  no words in memory, in flight, or buffered.
- level_o  out  AW+1  total unread words: memory, in flight, and buffered.

## Operation
- Pointer format: address counts 0..MEM_DEPTH-1. On increment from MEM_DEPTH-1, the address goes to 0 and the wrap bit toggles.
- mem_cnt is computed combinationally from wr_ptr_i and rd_ptr_o:
  - Equal wrap bits: wa − ra.
  - Otherwise: MEM_DEPTH − ra + wa.
  - Range 0..MEM_DEPTH.
- State:
  - pend: one-bit in-flight flag.
  - buf_cnt: 0..2.
  - Two data registers; the head drives m_data_o.
- pop = m_valid_o & m_ready_i.
- Issue condition: mem_rd_en_o = rd_rst_n & (mem_cnt ≠ 0) & (buf_cnt + pend − pop < 2).
  - On issue, rd_ptr_o advances by one and pend is set for the next cycle.
- Capture: when pend = 1, mem_rd_data_i is written into the buffer at its tail, after the pop has been applied in the same cycle.
- Same-cycle pop and capture: buf_cnt is unchanged.
- m_valid_o = (buf_cnt ≠ 0).
- m_data_o holds steady while m_valid_o & ~m_ready_i.
- empty_o = (mem_cnt = 0) & ~pend & (buf_cnt = 0).
- level_o = mem_cnt + pend + buf_cnt, computed at AW+1 bits; it never exceeds MEM_DEPTH.
- wr_ptr_i is never decreased by the writer. The block does not check for a write pointer that implies more than MEM_DEPTH words.

## Timing
- Reset values (asynchronous assertion):
  - rd_ptr_o = 0, pend = 0, buf_cnt = 0.
  - m_valid_o = 0, m_data_o = 0.
  - empty_o = 1, level_o = 0.
  - mem_rd_en_o is forced 0 while rd_rst_n is low.
- Reset release: synchronous to rd_clk.
- First-word latency: with the write pointer advanced and visible in cycle N, mem_rd_en_o is asserted in N, data returns in N+1, and m_valid_o is high in N+2.
- Throughput: one word per cycle with m_ready_i held high and mem_cnt > 0.
- Backpressure:
  - At most 2 words are buffered or in flight, plus none further issued.
  - With m_ready_i low, reads stop once buf_cnt + pend = 2.
- Reset mid-stream: the in-flight word is discarded, the buffer is cleared, and rd_ptr_o returns to 0. The write side must be reset together.
- Combinational paths: m_ready_i → mem_rd_en_o and wr_ptr_i → mem_rd_en_o/empty_o/level_o. No other input-to-output paths.

## Test plan
- Reset: assert rd_rst_n = 0 with wr_ptr_i = 5 → mem_rd_en_o = 0, m_valid_o = 0, empty_o = 1, rd_ptr_o = 0, level_o = 0. Release → reads begin on the first clock.
- Single word: memory[0] = 0xA5A5_0001, wr_ptr_i 0 → 1 in cycle N, m_ready_i high:
  - m_valid_o in N+2 with m_data_o = 0xA5A5_0001.
  - Popped in that cycle; empty_o = 1 in N+3.
  - level_o = 1 in N..N+2, then 0.
- Streaming: write 10 words, m_ready_i high → m_valid_o high for 10 consecutive cycles, data in order, no gaps.
- Wrap: MEM_DEPTH = 150, rd_ptr_o = {0,148}, wr_ptr_i = {1,2} → words from addresses 148, 149, 0, 1 delivered in order; rd_ptr_o ends at {1,2}; level_o starts at 4.
- Backpressure: 20 words available, m_ready_i low for 10 cycles:
  - Exactly 2 mem_rd_en_o pulses.
  - m_data_o stable and level_o = 20 throughout.
  - On release, all 20 words arrive in order.
- Full: wr_ptr_i = {1,0} from reset → level_o = 150; draining all 150 words yields empty_o = 1 and rd_ptr_o = {1,0}.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the universal FIFO: read pointer tracking, block-RAM
// read issue and a 2-entry first-word-fall-through prefetch buffer.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 150,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic [AW:0]           wr_ptr_i,
  output logic [AW:0]           rd_ptr_o,
  output logic                  mem_rd_en_o,
  output logic [AW-1:0]         mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  empty_o,
  output logic [AW:0]           level_o
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(MEM_DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(MEM_DEPTH - 1);

  logic [AW:0]           rd_ptr_q, rd_ptr_nxt;
  logic                  pend_q;
  logic [1:0]            buf_cnt_q, buf_cnt_nxt;
  logic [DATA_WIDTH-1:0] buf0_q, buf1_q, buf0_nxt, buf1_nxt;

  logic [AW-1:0] ra, wa;
  logic [AW:0]   mem_cnt_raw, mem_cnt;
  logic [2:0]    occ_after;
  logic [1:0]    tail;
  logic          pop, issue;

  assign ra = rd_ptr_q[AW-1:0];
  assign wa = wr_ptr_i[AW-1:0];

  always_comb begin
    if (wr_ptr_i[AW] == rd_ptr_q[AW])
      mem_cnt_raw = {1'b0, wa} - {1'b0, ra};
    else
      mem_cnt_raw = DEPTH_W - {1'b0, ra} + {1'b0, wa};
  end

  // Held at zero in reset so empty/level report an empty FIFO regardless of wr_ptr_i.
  assign mem_cnt = rd_rst_n ? mem_cnt_raw : '0;

  assign pop       = m_valid_o & m_ready_i;
  assign occ_after = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
  assign issue     = rd_rst_n & (mem_cnt != '0) & (occ_after < 3'd2);

  always_comb begin
    if (ra == LAST_A)
      rd_ptr_nxt = {~rd_ptr_q[AW], {AW{1'b0}}};
    else
      rd_ptr_nxt = {rd_ptr_q[AW], ra + AW'(1)};
  end

  // Pop shifts the buffer first; returned data then lands at the post-pop tail.
  always_comb begin
    buf0_nxt    = buf0_q;
    buf1_nxt    = buf1_q;
    buf_cnt_nxt = buf_cnt_q - {1'b0, pop} + {1'b0, pend_q};
    tail        = buf_cnt_q - {1'b0, pop};
    if (pop)
      buf0_nxt = buf1_q;
    if (pend_q) begin
      if (tail == 2'd0)
        buf0_nxt = mem_rd_data_i;
      else
        buf1_nxt = mem_rd_data_i;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q  <= '0;
      pend_q    <= 1'b0;
      buf_cnt_q <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      if (issue)
        rd_ptr_q <= rd_ptr_nxt;
      pend_q    <= issue;
      buf_cnt_q <= buf_cnt_nxt;
      buf0_q    <= buf0_nxt;
      buf1_q    <= buf1_nxt;
    end
  end

  assign rd_ptr_o      = rd_ptr_q;
  assign mem_rd_en_o   = issue;
  assign mem_rd_addr_o = ra;
  assign m_valid_o     = (buf_cnt_q != 2'd0);
  assign m_data_o      = buf0_q;
  assign empty_o       = (mem_cnt == '0) & ~pend_q & (buf_cnt_q == 2'd0);
  assign level_o       = mem_cnt + {{AW{1'b0}}, pend_q} + (AW+1)'(buf_cnt_q);

endmodule
